// File: rtl/logic_op_pipe.sv
// Registered N-bit logic unit with valid/ready handshakes on both sides.
// An output register plus one skid register keep full throughput under backpressure.
module logic_op_pipe #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     F,
    output logic [2:0]       F_op,
    output logic [CNT_W-1:0] done_cnt
);

    logic             r_outValid;
    logic [N-1:0]     r_outData;
    logic [2:0]       r_outOp;
    logic             r_skidValid;
    logic [N-1:0]     r_skidData;
    logic [2:0]       r_skidOp;
    logic [CNT_W-1:0] r_doneCnt;

    logic [N-1:0]     w_result;
    logic             w_accept;
    logic             w_drain;

    always_comb begin
        w_result = '0;
        case (op)
            3'b000:  w_result = A & B;
            3'b001:  w_result = ~(A & B);
            3'b010:  w_result = A | B;
            3'b011:  w_result = ~(A | B);
            3'b100:  w_result = A ^ B;
            3'b101:  w_result = ~(A ^ B);
            3'b110:  w_result = ~A;
            default: w_result = A;
        endcase
    end

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
    assign w_accept = in_valid & ~r_skidValid;
    assign w_drain  = r_outValid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outOp     <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidOp    <= '0;
        end else if (w_drain) begin
            if (r_skidValid) begin
                r_outData   <= r_skidData;
                r_outOp     <= r_skidOp;
                r_skidValid <= 1'b0;
            end else if (w_accept) begin
                r_outData <= w_result;
                r_outOp   <= op;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_outValid) begin
                r_outValid <= 1'b1;
                r_outData  <= w_result;
                r_outOp    <= op;
            end else begin
                r_skidValid <= 1'b1;
                r_skidData  <= w_result;
                r_skidOp    <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_doneCnt <= '0;
        end else if (w_drain) begin
            r_doneCnt <= r_doneCnt + CNT_W'(1);
        end
    end

    assign in_ready  = ~r_skidValid;
    assign out_valid = r_outValid;
    assign F         = r_outData;
    assign F_op      = r_outOp;
    assign done_cnt  = r_doneCnt;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed and randomized checks of logic_op_pipe (N=4, CNT_W=8): op map, skid
// backpressure, reset, counter wrap, and FIFO ordering against a truth-table reference queue.
module tb_logic_op_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] F;
    logic [2:0] F_op;
    logic [7:0] done_cnt;

    int total;
    int bad;

    logic [6:0] refQueue[$];
    logic [7:0] refDone;

    logic [3:0] sweepF[8];

    logic       stimValid;
    logic       stimReady;
    logic [3:0] stimA;
    logic [3:0] stimB;
    logic [2:0] stimOp;
    logic       mdlReady;
    int         accepted;
    int         cycles;

    logic_op_pipe #(.N(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .F_op      (F_op),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit truth table indexed by {a,b}, deliberately unlike the RTL's operator form.
    function automatic logic [3:0] refLogic(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] tbl;
        logic [3:0] res;
        case (o)
            3'd0:    tbl = 4'b1000;
            3'd1:    tbl = 4'b0111;
            3'd2:    tbl = 4'b1110;
            3'd3:    tbl = 4'b0001;
            3'd4:    tbl = 4'b0110;
            3'd5:    tbl = 4'b1001;
            3'd6:    tbl = 4'b0011;
            default: tbl = 4'b1100;
        endcase
        for (int i = 0; i < 4; i++) begin
            res[i] = tbl[{a[i], b[i]}];
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs at the falling edge and returns just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] o, input logic r);
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        op        = o;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        A         = 4'd0;
        B         = 4'd0;
        sweepF    = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0101, 4'b1010};

        #3 rst_n = 1'b0;
        #4;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_F", F, 0);
        checkOutput("rst_F_op", F_op, 0);
        checkOutput("rst_done_cnt", done_cnt, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Op sweep with the consumer always ready.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'b1010, 4'b0101, 3'(k), 1'b1);
            checkOutput($sformatf("sweep_valid_%0d", k), out_valid, 1);
            checkOutput($sformatf("sweep_F_%0d", k), F, sweepF[k]);
            checkOutput($sformatf("sweep_op_%0d", k), F_op, k);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("sweep_done_cnt", done_cnt, 8);
        checkOutput("sweep_empty", out_valid, 0);

        // Backpressure fills OUT then SKID; held inputs must be ignored while in_ready is low.
        applyStimulus(1'b1, 4'b1100, 4'b1111, 3'b001, 1'b0);
        checkOutput("bp_F_first", F, 4'b0011);
        checkOutput("bp_ready_first", in_ready, 1);
        applyStimulus(1'b1, 4'b1100, 4'b1111, 3'b000, 1'b0);
        checkOutput("bp_F_held", F, 4'b0011);
        checkOutput("bp_in_ready_low", in_ready, 0);
        applyStimulus(1'b1, 4'b0110, 4'b1001, 3'b010, 1'b0);
        applyStimulus(1'b1, 4'b0001, 4'b0111, 3'b111, 1'b0);
        checkOutput("hold_F", F, 4'b0011);
        checkOutput("hold_op", F_op, 3'b001);
        checkOutput("hold_in_ready", in_ready, 0);
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("bp_F_second", F, 4'b1100);
        checkOutput("bp_op_second", F_op, 3'b000);
        checkOutput("bp_ready_back", in_ready, 1);
        checkOutput("bp_done_9", done_cnt, 9);
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("bp_drained", out_valid, 0);
        checkOutput("bp_done_10", done_cnt, 10);

        // Accept and drain in the same cycle with SKID empty.
        applyStimulus(1'b1, 4'b0011, 4'b0101, 3'b100, 1'b0);
        checkOutput("sim_F_first", F, 4'b0110);
        applyStimulus(1'b1, 4'b0011, 4'b0101, 3'b000, 1'b1);
        checkOutput("sim_F_new", F, 4'b0001);
        checkOutput("sim_op_new", F_op, 3'b000);
        checkOutput("sim_valid", out_valid, 1);
        checkOutput("sim_in_ready", in_ready, 1);
        checkOutput("sim_done", done_cnt, 11);
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("sim_skid_empty", out_valid, 0);
        checkOutput("sim_done_12", done_cnt, 12);

        // Mid-stream asynchronous reset with both entries occupied.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 3'b010, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 3'b011, 1'b0);
        checkOutput("mid_pre_in_ready", in_ready, 0);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_F", F, 0);
        checkOutput("mid_rst_done", done_cnt, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("mid_rst_discard", out_valid, 0);
        checkOutput("mid_rst_no_count", done_cnt, 0);

        // Counter wrap after 256 handshakes.
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 4'(k), 4'(k >> 4), 3'(k), 1'b1);
        end
        checkOutput("wrap_255", done_cnt, 255);
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        checkOutput("wrap_zero", done_cnt, 0);
        checkOutput("wrap_empty", out_valid, 0);

        // Random valid/ready traffic against the reference queue.
        resetDut();
        refQueue.delete();
        refDone  = 8'd0;
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 40000) begin
            stimValid = ($urandom_range(0, 3) != 0);
            stimReady = ($urandom_range(0, 3) != 0);
            stimA     = 4'($urandom_range(0, 15));
            stimB     = 4'($urandom_range(0, 15));
            stimOp    = 3'($urandom_range(0, 7));
            mdlReady  = (refQueue.size() < 2);
            applyStimulus(stimValid, stimA, stimB, stimOp, stimReady);
            cycles++;
            if (refQueue.size() > 0 && stimReady) begin
                void'(refQueue.pop_front());
                refDone = refDone + 8'd1;
            end
            if (stimValid && mdlReady) begin
                refQueue.push_back({stimOp, refLogic(stimOp, stimA, stimB)});
                accepted++;
            end
            checkOutput("rnd_valid", out_valid, (refQueue.size() > 0) ? 1 : 0);
            checkOutput("rnd_in_ready", in_ready, (refQueue.size() < 2) ? 1 : 0);
            checkOutput("rnd_done", done_cnt, refDone);
            if (refQueue.size() > 0) begin
                checkOutput("rnd_result", {F_op, F}, refQueue[0]);
            end
        end
        checkOutput("rnd_budget", (accepted >= 10000) ? 1 : 0, 1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
            if (refQueue.size() > 0) begin
                void'(refQueue.pop_front());
                refDone = refDone + 8'd1;
            end
        end
        checkOutput("rnd_final_valid", out_valid, 0);
        checkOutput("rnd_final_done", done_cnt, refDone);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
